// File: rtl/mem_read_arbiter.sv
// Two-port read arbiter in front of a single AXI read memory port.
// One burst is in flight at a time: the grant is taken in IDLE, the address
// is presented in ADDR, and read beats are steered to the winner in DATA.
// Ties between the two requesters are broken round-robin.
module mem_read_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  aclk,
  input  logic                  resetn,
  // requester 0
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [7:0]            s0_axi_arlen,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  // requester 1
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [7:0]            s1_axi_arlen,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  // memory read-address channel
  output logic [ID_WIDTH-1:0]   m_mem_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_mem_axi_araddr,
  output logic [7:0]            m_mem_axi_arlen,
  output logic [2:0]            m_mem_axi_arsize,
  output logic [1:0]            m_mem_axi_arburst,
  output logic                  m_mem_axi_arvalid,
  input  logic                  m_mem_axi_arready,
  // memory read-data channel
  input  logic [ID_WIDTH-1:0]   m_mem_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_mem_axi_rdata,
  input  logic [1:0]            m_mem_axi_rresp,
  input  logic                  m_mem_axi_rlast,
  input  logic                  m_mem_axi_rvalid,
  output logic                  m_mem_axi_rready,
  output logic                  protocol_error
);

  // Every beat carries the full data bus width.
  localparam logic [2:0] LP_ARSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last_grant;
  logic                  r_grant;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [ID_WIDTH-1:0]   r_arid;
  logic [8:0]            r_beat_cnt;
  logic                  r_protocol_error;

  logic                  w_grant_vld;
  logic                  w_grant_idx;
  logic                  w_rready;
  logic                  w_beat_acc;
  logic                  w_in_data;
  logic                  w_bad_last;
  logic                  w_bad_id;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode plus the grant and ready strobes of the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_idx = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      IDLE: begin
        // resetn gating keeps arready low while reset is held.
        if (resetn && s0_axi_arvalid && s1_axi_arvalid) begin
          w_grant_vld = 1'b1;
          w_grant_idx = ~r_last_grant;
        end else if (resetn && s0_axi_arvalid) begin
          w_grant_vld = 1'b1;
          w_grant_idx = 1'b0;
        end else if (resetn && s1_axi_arvalid) begin
          w_grant_vld = 1'b1;
          w_grant_idx = 1'b1;
        end
        if (w_grant_vld) w_state_nxt = ADDR;
      end
      ADDR: begin
        if (m_mem_axi_arready) w_state_nxt = DATA;
      end
      DATA: begin
        w_rready = r_grant ? s1_axi_rready : s0_axi_rready;
        // Only rlast closes a burst, even one that overruns its length.
        if (m_mem_axi_rvalid && w_rready && m_mem_axi_rlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_in_data  = (r_state == DATA);
  assign w_beat_acc = m_mem_axi_rvalid & w_rready;
  assign w_bad_last = m_mem_axi_rlast & (r_beat_cnt != {1'b0, r_arlen});
  assign w_bad_id   = (m_mem_axi_rid != r_arid);

  // Latch the winning request, track beats and flag malformed bursts.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant     <= 1'b1;
      r_grant          <= 1'b0;
      r_araddr         <= '0;
      r_arlen          <= '0;
      r_arid           <= '0;
      r_beat_cnt       <= '0;
      r_protocol_error <= 1'b0;
    end else begin
      if (w_grant_vld) begin
        r_grant      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_araddr     <= w_grant_idx ? s1_axi_araddr : s0_axi_araddr;
        r_arlen      <= w_grant_idx ? s1_axi_arlen  : s0_axi_arlen;
        r_arid       <= ID_WIDTH'(w_grant_idx);
      end
      if (r_state == ADDR && m_mem_axi_arready) begin
        r_beat_cnt <= '0;
      end else if (w_beat_acc && r_beat_cnt != 9'h1FF) begin
        r_beat_cnt <= r_beat_cnt + 9'd1;
      end
      if (w_beat_acc && (w_bad_last || w_bad_id)) begin
        r_protocol_error <= 1'b1;
      end
    end
  end

  assign s0_axi_arready    = w_grant_vld & ~w_grant_idx;
  assign s1_axi_arready    = w_grant_vld &  w_grant_idx;

  assign m_mem_axi_arvalid = (r_state == ADDR);
  assign m_mem_axi_araddr  = r_araddr;
  assign m_mem_axi_arlen   = r_arlen;
  assign m_mem_axi_arid    = r_arid;
  assign m_mem_axi_arsize  = LP_ARSIZE;
  assign m_mem_axi_arburst = 2'b01;

  assign m_mem_axi_rready  = w_rready;
  assign s0_axi_rdata      = m_mem_axi_rdata;
  assign s1_axi_rdata      = m_mem_axi_rdata;
  assign s0_axi_rresp      = m_mem_axi_rresp;
  assign s1_axi_rresp      = m_mem_axi_rresp;
  assign s0_axi_rvalid     = w_in_data & ~r_grant & m_mem_axi_rvalid;
  assign s1_axi_rvalid     = w_in_data &  r_grant & m_mem_axi_rvalid;
  assign s0_axi_rlast      = w_in_data & ~r_grant & m_mem_axi_rlast;
  assign s1_axi_rlast      = w_in_data &  r_grant & m_mem_axi_rlast;

  assign protocol_error    = r_protocol_error;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: the bench plays both requesters and the memory,
// predicts the arbiter's outputs each cycle from a transaction-level model
// and runs a sequence of directed and randomized scenarios.
module tb_mem_read_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int IW = 8;

  logic          aclk = 1'b0;
  logic          resetn;
  logic [AW-1:0] s0_axi_araddr, s1_axi_araddr;
  logic [7:0]    s0_axi_arlen, s1_axi_arlen;
  logic          s0_axi_arvalid, s1_axi_arvalid;
  logic          s0_axi_arready, s1_axi_arready;
  logic [DW-1:0] s0_axi_rdata, s1_axi_rdata;
  logic [1:0]    s0_axi_rresp, s1_axi_rresp;
  logic          s0_axi_rlast, s1_axi_rlast;
  logic          s0_axi_rvalid, s1_axi_rvalid;
  logic          s0_axi_rready, s1_axi_rready;
  logic [IW-1:0] m_mem_axi_arid;
  logic [AW-1:0] m_mem_axi_araddr;
  logic [7:0]    m_mem_axi_arlen;
  logic [2:0]    m_mem_axi_arsize;
  logic [1:0]    m_mem_axi_arburst;
  logic          m_mem_axi_arvalid, m_mem_axi_arready;
  logic [IW-1:0] m_mem_axi_rid;
  logic [DW-1:0] m_mem_axi_rdata;
  logic [1:0]    m_mem_axi_rresp;
  logic          m_mem_axi_rlast, m_mem_axi_rvalid, m_mem_axi_rready;
  logic          protocol_error;

  mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .resetn(resetn),
    .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid),
    .s0_axi_rready(s0_axi_rready),
    .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid),
    .s1_axi_rready(s1_axi_rready),
    .m_mem_axi_arid(m_mem_axi_arid), .m_mem_axi_araddr(m_mem_axi_araddr),
    .m_mem_axi_arlen(m_mem_axi_arlen), .m_mem_axi_arsize(m_mem_axi_arsize),
    .m_mem_axi_arburst(m_mem_axi_arburst), .m_mem_axi_arvalid(m_mem_axi_arvalid),
    .m_mem_axi_arready(m_mem_axi_arready),
    .m_mem_axi_rid(m_mem_axi_rid), .m_mem_axi_rdata(m_mem_axi_rdata),
    .m_mem_axi_rresp(m_mem_axi_rresp), .m_mem_axi_rlast(m_mem_axi_rlast),
    .m_mem_axi_rvalid(m_mem_axi_rvalid), .m_mem_axi_rready(m_mem_axi_rready),
    .protocol_error(protocol_error)
  );

  always #5 aclk = ~aclk;

  // Requester state driven onto the DUT address channels.
  logic          s_v [2];
  logic [AW-1:0] s_a [2];
  logic [7:0]    s_l [2];
  assign s0_axi_arvalid = s_v[0];
  assign s1_axi_arvalid = s_v[1];
  assign s0_axi_araddr  = s_a[0];
  assign s1_axi_araddr  = s_a[1];
  assign s0_axi_arlen   = s_l[0];
  assign s1_axi_arlen   = s_l[1];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Transaction-level model: which phase the single burst is in, who owns it.
  int            ph;          // 0 no burst, 1 address offered, 2 data returning
  int            mport;
  logic [AW-1:0] maddr;
  logic [7:0]    mlen;
  int            mbeats;
  int            mlast;
  logic          merr;
  logic          hs [2];
  int            gnt_log[$];
  int            burst_log[$];

  // Stimulus knobs.
  int  req_pct [2];
  int  drop_pct;
  int  len_max;
  int  arr_pct, rv_pct, rr_pct;
  bit  rr_toggle, tog;
  bit  early_rlast, late_rlast, bad_rid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; mport = 0; maddr = '0; mlen = '0; mbeats = 0; mlast = 1; merr = 1'b0;
    hs[0] = 1'b0; hs[1] = 1'b0;
  endtask

  // Winner of an address handshake this cycle, or -1.
  function automatic int pick();
    if (ph != 0 || !resetn) return -1;
    if (s_v[0] && s_v[1]) return (mlast == 0) ? 1 : 0;
    if (s_v[0]) return 0;
    if (s_v[1]) return 1;
    return -1;
  endfunction

  function automatic logic port_rready(int p);
    return (p == 1) ? s1_axi_rready : s0_axi_rready;
  endfunction

  task automatic check_outputs();
    int   g;
    logic rr;
    g  = pick();
    rr = (ph == 2) && port_rready(mport);
    check("s0_arready", s0_axi_arready, g == 0);
    check("s1_arready", s1_axi_arready, g == 1);
    check("arvalid", m_mem_axi_arvalid, ph == 1);
    check("araddr", m_mem_axi_araddr, maddr);
    check("arlen", m_mem_axi_arlen, mlen);
    check("arid", m_mem_axi_arid, IW'(mport));
    check("arsize", m_mem_axi_arsize, 3'd1);
    check("arburst", m_mem_axi_arburst, 2'b01);
    check("m_rready", m_mem_axi_rready, rr);
    check("s0_rvalid", s0_axi_rvalid, (ph == 2) && (mport == 0) && m_mem_axi_rvalid);
    check("s1_rvalid", s1_axi_rvalid, (ph == 2) && (mport == 1) && m_mem_axi_rvalid);
    if (ph == 2 && m_mem_axi_rvalid) begin
      if (mport == 0) begin
        check("s0_rdata", s0_axi_rdata, m_mem_axi_rdata);
        check("s0_rresp", s0_axi_rresp, m_mem_axi_rresp);
        check("s0_rlast", s0_axi_rlast, m_mem_axi_rlast);
      end else begin
        check("s1_rdata", s1_axi_rdata, m_mem_axi_rdata);
        check("s1_rresp", s1_axi_rresp, m_mem_axi_rresp);
        check("s1_rlast", s1_axi_rlast, m_mem_axi_rlast);
      end
    end
    check("protocol_error", protocol_error, merr);
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step();
    int g;
    hs[0] = 1'b0; hs[1] = 1'b0;
    case (ph)
      0: begin
        g = pick();
        if (g >= 0) begin
          mport = g; maddr = s_a[g]; mlen = s_l[g]; mlast = g;
          hs[g] = 1'b1; ph = 1;
          gnt_log.push_back(g);
        end
      end
      1: if (m_mem_axi_arready) begin ph = 2; mbeats = 0; end
      default: begin
        if (m_mem_axi_rvalid && port_rready(mport)) begin
          if (m_mem_axi_rid != IW'(mport)) merr = 1'b1;
          bad_rid = 1'b0;
          if (m_mem_axi_rlast) begin
            if (mbeats != int'(mlen)) merr = 1'b1;
            burst_log.push_back(mbeats + 1);
            early_rlast = 1'b0; late_rlast = 1'b0;
            ph = 0;
          end
          mbeats++;
        end
      end
    endcase
  endtask

  task automatic drive();
    for (int n = 0; n < 2; n++) begin
      if (hs[n]) s_v[n] = 1'b0;
      if (!s_v[n] && $urandom_range(99) < req_pct[n]) begin
        s_v[n] = 1'b1;
        s_a[n] = AW'($urandom);
        s_l[n] = 8'($urandom_range(len_max));
      end else if (s_v[n] && !hs[n] && drop_pct > 0 && $urandom_range(99) < drop_pct) begin
        s_v[n] = 1'b0;
      end
    end
    m_mem_axi_arready = ($urandom_range(99) < arr_pct);
    m_mem_axi_rvalid  = ($urandom_range(99) < rv_pct);
    m_mem_axi_rdata   = DW'($urandom);
    m_mem_axi_rresp   = 2'($urandom);
    if (ph == 2) begin
      m_mem_axi_rid   = bad_rid ? IW'(5) : IW'(mport);
      if (early_rlast)     m_mem_axi_rlast = (mbeats == 1);
      else if (late_rlast) m_mem_axi_rlast = (mbeats == int'(mlen) + 2);
      else                 m_mem_axi_rlast = (mbeats == int'(mlen));
    end else begin
      m_mem_axi_rid   = IW'($urandom);
      m_mem_axi_rlast = 1'($urandom);
    end
    if (rr_toggle) begin
      tog = ~tog;
      s0_axi_rready = tog;
      s1_axi_rready = tog;
    end else begin
      s0_axi_rready = ($urandom_range(99) < rr_pct);
      s1_axi_rready = ($urandom_range(99) < rr_pct);
    end
  endtask

  // One clock: drive at the falling edge, check, predict, wait for next fall.
  task automatic cycle();
    drive();
    #1;
    check_outputs();
    model_step();
    @(negedge aclk);
  endtask

  task automatic run_bursts(input int nb, input int budget);
    int k = 0;
    while (burst_log.size() < nb && k < budget) begin
      cycle();
      k++;
    end
    check("burst_count", burst_log.size(), nb);
  endtask

  task automatic fast_mem();
    arr_pct = 100; rv_pct = 100; rr_pct = 100; rr_toggle = 1'b0;
  endtask

  task automatic request(input int n, input logic [AW-1:0] a, input logic [7:0] l);
    s_v[n] = 1'b1; s_a[n] = a; s_l[n] = l; hs[n] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    req_pct[0] = 0; req_pct[1] = 0; drop_pct = 0;
    s_v[0] = 1'b0; s_v[1] = 1'b0; hs[0] = 1'b0; hs[1] = 1'b0;
    fast_mem();
    while (ph != 0 && k < 100) begin
      cycle();
      k++;
    end
    check("drain_timeout", k < 100, 1'b1);
    gnt_log.delete();
    burst_log.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rep;
    int k;
    // Reset with both requesters and memory rvalid active: nothing may leak out.
    resetn = 1'b0;
    req_pct[0] = 0; req_pct[1] = 0; drop_pct = 0; len_max = 3;
    rr_toggle = 1'b0; tog = 1'b0; early_rlast = 1'b0; late_rlast = 1'b0; bad_rid = 1'b0;
    fast_mem();
    model_reset();
    s_v[0] = 1'b1; s_a[0] = 24'h000100; s_l[0] = 8'd3;
    s_v[1] = 1'b1; s_a[1] = 24'h000200; s_l[1] = 8'd1;
    m_mem_axi_arready = 1'b1; m_mem_axi_rvalid = 1'b1; m_mem_axi_rlast = 1'b1;
    m_mem_axi_rid = '0; m_mem_axi_rdata = '0; m_mem_axi_rresp = '0;
    s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      #1;
      check_outputs();
    end
    @(negedge aclk);
    resetn = 1'b1;

    // Simultaneous requests after reset: port 0 first, then port 1.
    run_bursts(2, 60);
    check("first_grant", gnt_log[0], 0);
    check("second_grant", gnt_log[1], 1);
    check("s0_beats", burst_log[0], 4);
    check("s1_beats", burst_log[1], 2);
    check("perr_clean", protocol_error, 1'b0);
    drain();

    // Both hammering: grants must strictly alternate.
    req_pct[0] = 100; req_pct[1] = 100; len_max = 3;
    arr_pct = 70; rv_pct = 70; rr_pct = 80;
    run_bursts(20, 2000);
    rep = 0;
    for (int i = 1; i < gnt_log.size(); i++)
      if (gnt_log[i] == gnt_log[i-1]) rep++;
    check("rr_repeats", rep, 0);
    check("rr_first", gnt_log[0], 0);
    drain();

    // Address channel stalled for 5 cycles.
    request(1, 24'hABCDEF, 8'd2);
    arr_pct = 0;
    cycle();
    repeat (5) begin
      cycle();
      check("stall_arvalid", m_mem_axi_arvalid, 1'b1);
      check("stall_araddr", m_mem_axi_araddr, 24'hABCDEF);
    end
    arr_pct = 100;
    cycle();
    check("data_after_arready", m_mem_axi_arvalid, 1'b0);
    run_bursts(1, 40);
    check("stall_beats", burst_log[0], 3);
    drain();

    // rready toggling every cycle during an 8-beat burst.
    request(0, 24'h001000, 8'd7);
    rr_toggle = 1'b1;
    run_bursts(1, 60);
    check("toggle_beats", burst_log[0], 8);
    drain();

    // Early rlast, then a burst answered with the wrong rid.
    request(0, 24'h002000, 8'd3);
    early_rlast = 1'b1;
    run_bursts(1, 40);
    check("early_beats", burst_log[0], 2);
    check("perr_early", protocol_error, 1'b1);
    cycle();
    check("idle_after_early", m_mem_axi_arvalid | m_mem_axi_rready, 1'b0);
    burst_log.delete();
    request(1, 24'h003000, 8'd1);
    bad_rid = 1'b1;
    run_bursts(1, 40);
    check("perr_sticky", protocol_error, 1'b1);
    drain();

    // Reset pulse in the middle of a data burst.
    request(0, 24'h004000, 8'd5);
    k = 0;
    while (!(ph == 2 && mbeats == 2) && k < 40) begin
      cycle();
      k++;
    end
    check("reach_beat2", k < 40, 1'b1);
    m_mem_axi_rvalid = 1'b1;
    resetn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_s0_rvalid", s0_axi_rvalid, 1'b0);
    check("rst_perr", protocol_error, 1'b0);
    @(negedge aclk);
    resetn = 1'b1;
    s_v[0] = 1'b0;
    request(1, 24'h005000, 8'd0);
    gnt_log.delete(); burst_log.delete();
    run_bursts(1, 40);
    check("post_rst_grant", gnt_log[0], 1);
    drain();

    // Randomized traffic with requesters that sometimes withdraw.
    req_pct[0] = 30; req_pct[1] = 30; drop_pct = 10; len_max = 15;
    arr_pct = 60; rv_pct = 60; rr_pct = 70;
    repeat (1500) cycle();
    check("random_perr", protocol_error, 1'b0);
    drain();

    // Burst overrunning its length keeps going until rlast.
    request(0, 24'h006000, 8'd2);
    late_rlast = 1'b1;
    run_bursts(1, 40);
    check("late_beats", burst_log[0], 5);
    check("perr_late", protocol_error, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
